regfile_32x32: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the single-cycle/pipelined CPU datapath.
- Consumes the one-hot write-select produced by the existing 5-to-32 decoder (decoder_5to32) and gates it with the write enable.
- Provides two asynchronous read ports (rs/rt) and one synchronous write port (rd).
- Register 0 is hardwired to zero.

---
 rtl/regfile_32x32_pkg.sv | 14 +
 rtl/regfile_32x32_dec.sv | 11 +
 rtl/regfile_32x32.sv | 60 ++++++
 tb/tb_regfile_32x32.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_32x32_pkg.sv
// rtl/regfile_32x32_pkg.sv - shared constants and helpers for the 32x32 register file
package regfile_32x32_pkg;

  localparam int unsigned REG_COUNT      = 32;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = '0;

  // True when idx names the hardwired-zero entry of a file built with zero_en set.
  function automatic bit is_zero_reg(input logic [REG_ADDR_W-1:0] idx, input bit zero_en);
    return zero_en && (idx == ZERO_IDX);
  endfunction

endpackage

// File: rtl/regfile_32x32_dec.sv
// rtl/regfile_32x32_dec.sv - decoder_5to32: one-hot write-select decoder
module decoder_5to32
  import regfile_32x32_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  output logic [REG_COUNT-1:0]  dec
);

  assign dec = REG_COUNT'(1) << addr;

endmodule

// File: rtl/regfile_32x32.sv
// rtl/regfile_32x32.sv - 32x32 register file, 2 async reads, 1 sync write
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_32x32
  import regfile_32x32_pkg::*;
#(
  parameter int unsigned WIDTH    = DATA_W_DEFAULT,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]      rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_b
);

  logic [REG_COUNT-1:0]            dec;
  logic [REG_COUNT-1:0][WIDTH-1:0] regs;

  decoder_5to32 u_dec (
    .addr (wr_addr),
    .dec  (dec)
  );

  for (genvar k = 0; k < REG_COUNT; k++) begin : g_entry
    if (is_zero_reg(REG_ADDR_W'(k), ZERO_REG)) begin : g_zero
      // Hardwired zero: no storage, so writes to this index simply vanish.
      logic unused_dec;
      assign unused_dec = dec[k];
      assign regs[k]    = '0;
    end else begin : g_flop
      logic [WIDTH-1:0] q;
      always_ff @(posedge clk) begin
        if (reset) begin
          q <= '0;
        end else if (wr_en & dec[k]) begin
          q <= wr_data;
        end
      end
      assign regs[k] = q;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (!reset && wr_en && (wr_addr == rd_addr_a) && !is_zero_reg(rd_addr_a, ZERO_REG)) begin
      rd_data_a = wr_data;
    end
    if (!reset && wr_en && (wr_addr == rd_addr_b) && !is_zero_reg(rd_addr_b, ZERO_REG)) begin
      rd_data_b = wr_data;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_32x32.sv
// tb/tb_regfile_32x32.sv - randomized self-checking bench for regfile_32x32
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] a_z, b_z, a_n, b_n;

  int total = 0;
  int bad   = 0;

  // Architectural contents: m_z for the ZERO_REG=1 instance, m_n for ZERO_REG=0.
  logic [31:0] m_z [32];
  logic [31:0] m_n [32];

  always #5 clk = ~clk;

  regfile_32x32 #(.WIDTH(32), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(a_z), .rd_addr_b(rd_addr_b), .rd_data_b(b_z)
  );

  regfile_32x32 #(.WIDTH(32), .ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(a_n), .rd_addr_b(rd_addr_b), .rd_data_b(b_n)
  );

  function automatic logic [31:0] exp_rd(input bit zero, input logic [4:0] addr);
    logic [31:0] v;
    v = zero ? m_z[addr] : m_n[addr];
    if (zero && addr == 5'd0) v = 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && wr_en && addr == wr_addr && !(zero && addr == 5'd0)) v = wr_data;
`endif
    return v;
  endfunction

  // Advance one clock, applying the write/reset rules to the model, then settle.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_z[i] = 32'h0;
        m_n[i] = 32'h0;
      end
    end else if (wr_en) begin
      m_n[wr_addr] = wr_data;
      if (wr_addr != 5'd0) m_z[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic idle();
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'h0;
  endtask

  task automatic write(input logic [4:0] addr, input logic [31:0] data);
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    idle();
  endtask

  task automatic sweep(input string name);
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a);
      rd_addr_b = 5'(31 - a);
      #1;
      total += 4;
      if (a_z !== exp_rd(1'b1, rd_addr_a)) begin
        bad++; $display("FAIL %s z.a[%0d] got=%h want=%h", name, a, a_z, exp_rd(1'b1, rd_addr_a));
      end
      if (b_z !== exp_rd(1'b1, rd_addr_b)) begin
        bad++; $display("FAIL %s z.b[%0d] got=%h want=%h", name, rd_addr_b, b_z, exp_rd(1'b1, rd_addr_b));
      end
      if (a_n !== exp_rd(1'b0, rd_addr_a)) begin
        bad++; $display("FAIL %s n.a[%0d] got=%h want=%h", name, a, a_n, exp_rd(1'b0, rd_addr_a));
      end
      if (b_n !== exp_rd(1'b0, rd_addr_b)) begin
        bad++; $display("FAIL %s n.b[%0d] got=%h want=%h", name, rd_addr_b, b_n, exp_rd(1'b0, rd_addr_b));
      end
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a);
      rd_addr_b = 5'(a);
      #1;
      total++;
      if ({a_z, b_z, a_n, b_n} !== 128'h0) begin
        bad++; $display("FAIL reset_read[%0d] got=%h %h %h %h want=0", a, a_z, b_z, a_n, b_n);
      end
    end
  endtask

  task automatic test_write_readback();
    write(5'd5, 32'hDEADBEEF);
    write(5'd31, 32'h12345678);
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd31;
    #1;
    total += 2;
    if (a_z !== 32'hDEADBEEF) begin
      bad++; $display("FAIL readback_r5 got=%h want=deadbeef", a_z);
    end
    if (b_z !== 32'h12345678) begin
      bad++; $display("FAIL readback_r31 got=%h want=12345678", b_z);
    end
    sweep("readback_sweep");
  endtask

  task automatic test_zero_reg();
    write(5'd0, 32'hFFFFFFFF);
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    #1;
    total += 3;
    if (a_z !== 32'h0) begin
      bad++; $display("FAIL zero_reg_on got=%h want=0", a_z);
    end
    if (a_n !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL zero_reg_off got=%h want=ffffffff", a_n);
    end
    if (b_n !== a_n) begin
      bad++; $display("FAIL same_entry_both_ports got=%h want=%h", b_n, a_n);
    end
  endtask

  task automatic test_wr_en_gating();
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 5'd7;
    wr_data = 32'hA5A5A5A5;
    tick();
    wr_addr = 5'bx;
    wr_data = 32'h5A5A5A5A;
    tick();
    idle();
    rd_addr_a = 5'd7;
    #1;
    total++;
    if (a_z !== 32'h0) begin
      bad++; $display("FAIL wr_en_gating_r7 got=%h want=0", a_z);
    end
    sweep("gating_sweep");
  endtask

  task automatic test_same_cycle();
    logic [31:0] want_now;
`ifdef REGFILE_BYPASS_EN
    want_now = 32'h22;
`else
    want_now = 32'h11;
`endif
    write(5'd9, 32'h11);
    wr_en     = 1'b1;
    wr_addr   = 5'd9;
    wr_data   = 32'h22;
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd9;
    #1;
    total += 2;
    if (a_z !== want_now) begin
      bad++; $display("FAIL same_cycle_now got=%h want=%h", a_z, want_now);
    end
    if (b_n !== want_now) begin
      bad++; $display("FAIL same_cycle_now_b got=%h want=%h", b_n, want_now);
    end
    tick();
    idle();
    #1;
    total++;
    if (a_z !== 32'h22) begin
      bad++; $display("FAIL same_cycle_next got=%h want=00000022", a_z);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      wr_en     = $urandom_range(0, 1);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr_b = 5'($urandom_range(0, 31));
      #1;
      total += 4;
      if (a_z !== exp_rd(1'b1, rd_addr_a)) begin
        bad++; $display("FAIL rand z.a n=%0d addr=%0d got=%h want=%h", n, rd_addr_a, a_z, exp_rd(1'b1, rd_addr_a));
      end
      if (b_z !== exp_rd(1'b1, rd_addr_b)) begin
        bad++; $display("FAIL rand z.b n=%0d addr=%0d got=%h want=%h", n, rd_addr_b, b_z, exp_rd(1'b1, rd_addr_b));
      end
      if (a_n !== exp_rd(1'b0, rd_addr_a)) begin
        bad++; $display("FAIL rand n.a n=%0d addr=%0d got=%h want=%h", n, rd_addr_a, a_n, exp_rd(1'b0, rd_addr_a));
      end
      if (b_n !== exp_rd(1'b0, rd_addr_b)) begin
        bad++; $display("FAIL rand n.b n=%0d addr=%0d got=%h want=%h", n, rd_addr_b, b_n, exp_rd(1'b0, rd_addr_b));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_collision();
    for (int r = 1; r < 32; r++) write(5'(r), 32'(r));
    sweep("populate_sweep");
    reset     = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 5'd3;
    wr_data   = 32'h55;
    rd_addr_a = 5'd3;
    #1;
    total++;
    if (a_z !== 32'h3) begin
      bad++; $display("FAIL reset_cycle_no_forward got=%h want=00000003", a_z);
    end
    tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a);
      rd_addr_b = 5'(a);
      #1;
      total++;
      if ({a_z, b_z, a_n, b_n} !== 128'h0) begin
        bad++; $display("FAIL collision_clear[%0d] got=%h %h %h %h want=0", a, a_z, b_z, a_n, b_n);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_z[i] = 32'h0;
      m_n[i] = 32'h0;
    end
    idle();
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    #1;
    test_reset();
    test_write_readback();
    test_zero_reg();
    test_wr_en_gating();
    test_same_cycle();
    test_random();
    test_reset_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
